// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the IF/ID, ID/EXE and EXE/MEM registers.
// Produces PC/stage write enables and flush strobes from load-use hazards, taken
// branches, the multi-cycle divider, cache misses and MEM-stage exceptions, and
// counts cycles in which the PC was held.
module pipe_hazard_ctrl #(
  parameter int DIV_LAT_MAX = 36,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EXE_MemRead,
  input  logic [4:0]       EXE_rt,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             EXE_BranchTaken,
  input  logic             EXE_DivStart,
  input  logic             Div_Done,
  input  logic             ICache_Busy,
  input  logic             DCache_Busy,
  input  logic             Exc_Valid,
  output logic             PC_Wr,
  output logic             ID_Wr,
  output logic             ID_Flush,
  output logic             EXE_Wr,
  output logic             EXE_Flush,
  output logic             MEM_Flush,
  output logic             Div_Timeout,
  output logic [CNT_W-1:0] Stall_Cnt
);

  // Divider wait counter only has to reach DIV_LAT_MAX-1.
  localparam int DCW = $clog2(DIV_LAT_MAX);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_LAT_MAX - 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_DIV_WAIT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [DCW-1:0]   div_cnt_reg, div_cnt_next;
  logic             done_pend_reg, done_pend_next;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic cache_busy;
  logic load_use_hit;
  logic div_finished;
  logic div_expired;

  // Register zero is never a real dependency, so a load to r0 never stalls.
  assign cache_busy   = ICache_Busy | DCache_Busy;
  assign load_use_hit = EXE_MemRead && (EXE_rt != 5'd0) &&
                        ((EXE_rt == ID_rs) || (EXE_rt == ID_rt));
  // A done pulse that arrived while frozen is remembered in done_pend.
  assign div_finished = Div_Done | done_pend_reg;
  assign div_expired  = (div_cnt_reg == DIV_LAST);

  // State, divider wait counter and pending-done flag.
  always_ff @(posedge clk) begin
    state_reg     <= state_next;
    div_cnt_reg   <= div_cnt_next;
    done_pend_reg <= done_pend_next;
  end

  // Next-state and strobe decode, resolved strictly in priority order.
  always_comb begin
    PC_Wr          = 1'b1;
    ID_Wr          = 1'b1;
    EXE_Wr         = 1'b1;
    ID_Flush       = 1'b0;
    EXE_Flush      = 1'b0;
    MEM_Flush      = 1'b0;
    Div_Timeout    = 1'b0;
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    done_pend_next = done_pend_reg;

    if (rst) begin
      // Hold every stage and keep all pipeline registers cleared.
      PC_Wr          = 1'b0;
      ID_Wr          = 1'b0;
      EXE_Wr         = 1'b0;
      ID_Flush       = 1'b1;
      EXE_Flush      = 1'b1;
      MEM_Flush      = 1'b1;
      state_next     = ST_RUN;
      div_cnt_next   = '0;
      done_pend_next = 1'b0;
    end else if (Exc_Valid) begin
      // PC loads the exception vector; everything younger than MEM is killed.
      PC_Wr          = 1'b1;
      ID_Wr          = 1'b0;
      ID_Flush       = 1'b1;
      EXE_Flush      = 1'b1;
      MEM_Flush      = 1'b1;
      state_next     = ST_RUN;
      div_cnt_next   = '0;
      done_pend_next = 1'b0;
    end else if (cache_busy) begin
      // Full freeze: nothing moves, the divider timeout does not run either.
      PC_Wr  = 1'b0;
      ID_Wr  = 1'b0;
      EXE_Wr = 1'b0;
      if (Div_Done) begin
        done_pend_next = 1'b1;
      end
    end else if (state_reg == ST_DIV_WAIT) begin
      if (div_finished) begin
        // Divider result is ready: release the pipeline this cycle.
        state_next     = ST_RUN;
        div_cnt_next   = '0;
        done_pend_next = 1'b0;
      end else if (div_expired) begin
        // Give up on the divider and let the pipeline continue.
        Div_Timeout    = 1'b1;
        state_next     = ST_RUN;
        div_cnt_next   = '0;
        done_pend_next = 1'b0;
      end else begin
        // Hold front end; the divide stays in EXE and bubbles go to MEM.
        PC_Wr        = 1'b0;
        ID_Wr        = 1'b0;
        EXE_Wr       = 1'b0;
        MEM_Flush    = 1'b1;
        div_cnt_next = div_cnt_reg + DCW'(1);
      end
    end else begin
      if (EXE_DivStart) begin
        // Divide issue cycle advances normally; the wait starts next cycle.
        state_next     = ST_DIV_WAIT;
        div_cnt_next   = '0;
        done_pend_next = 1'b0;
      end else if (EXE_BranchTaken) begin
        // Redirect PC and squash the wrong-path fetch in IF/ID.
        ID_Wr    = 1'b0;
        ID_Flush = 1'b1;
      end else if (load_use_hit) begin
        // Hold IF/ID one cycle and insert a bubble behind the load.
        PC_Wr     = 1'b0;
        ID_Wr     = 1'b0;
        EXE_Flush = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!PC_Wr && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign Stall_Cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. A narrow stall counter is used so that
// saturation can be reached in a short run.
module tb_pipe_hazard_ctrl;

  localparam int DIV_LAT_MAX = 36;
  localparam int CNT_W       = 6;

  // Output vector layout: {PC_Wr, ID_Wr, EXE_Wr, ID_Flush, EXE_Flush, MEM_Flush, Div_Timeout}
  localparam logic [6:0] O_RESET = 7'b000_111_0;
  localparam logic [6:0] O_DEF   = 7'b111_000_0;
  localparam logic [6:0] O_LU    = 7'b001_010_0;
  localparam logic [6:0] O_BR    = 7'b101_100_0;
  localparam logic [6:0] O_FRZ   = 7'b000_000_0;
  localparam logic [6:0] O_DW    = 7'b000_001_0;
  localparam logic [6:0] O_TO    = 7'b111_000_1;
  // Exception vector without EXE_Wr: {PC_Wr, ID_Wr, ID_Flush, EXE_Flush, MEM_Flush, Div_Timeout}
  localparam logic [5:0] O_EXC   = 6'b10_1110;

  logic             clk = 1'b0;
  logic             rst;
  logic             EXE_MemRead;
  logic [4:0]       EXE_rt;
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             EXE_BranchTaken;
  logic             EXE_DivStart;
  logic             Div_Done;
  logic             ICache_Busy;
  logic             DCache_Busy;
  logic             Exc_Valid;
  logic             PC_Wr;
  logic             ID_Wr;
  logic             ID_Flush;
  logic             EXE_Wr;
  logic             EXE_Flush;
  logic             MEM_Flush;
  logic             Div_Timeout;
  logic [CNT_W-1:0] Stall_Cnt;

  int checks   = 0;
  int failures = 0;

  logic [6:0] outs;
  logic [5:0] outs_exc;
  assign outs     = {PC_Wr, ID_Wr, EXE_Wr, ID_Flush, EXE_Flush, MEM_Flush, Div_Timeout};
  assign outs_exc = {PC_Wr, ID_Wr, ID_Flush, EXE_Flush, MEM_Flush, Div_Timeout};

  pipe_hazard_ctrl #(
    .DIV_LAT_MAX(DIV_LAT_MAX),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .EXE_MemRead    (EXE_MemRead),
    .EXE_rt         (EXE_rt),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_DivStart   (EXE_DivStart),
    .Div_Done       (Div_Done),
    .ICache_Busy    (ICache_Busy),
    .DCache_Busy    (DCache_Busy),
    .Exc_Valid      (Exc_Valid),
    .PC_Wr          (PC_Wr),
    .ID_Wr          (ID_Wr),
    .ID_Flush       (ID_Flush),
    .EXE_Wr         (EXE_Wr),
    .EXE_Flush      (EXE_Flush),
    .MEM_Flush      (MEM_Flush),
    .Div_Timeout    (Div_Timeout),
    .Stall_Cnt      (Stall_Cnt)
  );

  always #5 clk = ~clk;

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    EXE_MemRead     = 1'b0;
    EXE_rt          = 5'd0;
    ID_rs           = 5'd0;
    ID_rt           = 5'd0;
    EXE_BranchTaken = 1'b0;
    EXE_DivStart    = 1'b0;
    Div_Done        = 1'b0;
    ICache_Busy     = 1'b0;
    DCache_Busy     = 1'b0;
    Exc_Valid       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (outs !== O_RESET) begin
      failures++;
      $display("FAIL reset_outs: got %b required %b", outs, O_RESET);
    end
    cycle();
    // Reset must dominate a cache miss and an exception.
    DCache_Busy = 1'b1;
    Exc_Valid   = 1'b1;
    #1;
    checks++;
    if (outs !== O_RESET) begin
      failures++;
      $display("FAIL reset_priority: got %b required %b", outs, O_RESET);
    end
    cycle();
    checks++;
    if (Stall_Cnt !== '0) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %0d required 0", Stall_Cnt);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL release_outs: got %b required %b", outs, O_DEF);
    end
    cycle();
    checks++;
    if (Stall_Cnt !== 6'd0) begin
      failures++;
      $display("FAIL release_stall_cnt: got %0d required 0", Stall_Cnt);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_load_use();
    do_reset();
    // rs match
    EXE_MemRead = 1'b1; EXE_rt = 5'd5; ID_rs = 5'd5; ID_rt = 5'd7;
    #1;
    checks++;
    if (outs !== O_LU) begin
      failures++;
      $display("FAIL lu_rs_outs: got %b required %b", outs, O_LU);
    end
    cycle();
    clear_inputs();
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL lu_one_cycle: got %b required %b", outs, O_DEF);
    end
    checks++;
    if (Stall_Cnt !== 6'd1) begin
      failures++;
      $display("FAIL lu_stall_cnt1: got %0d required 1", Stall_Cnt);
    end
    // rt match
    EXE_MemRead = 1'b1; EXE_rt = 5'd9; ID_rs = 5'd3; ID_rt = 5'd9;
    #1;
    checks++;
    if (outs !== O_LU) begin
      failures++;
      $display("FAIL lu_rt_outs: got %b required %b", outs, O_LU);
    end
    cycle();
    // load to r0 never stalls
    EXE_MemRead = 1'b1; EXE_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL lu_r0: got %b required %b", outs, O_DEF);
    end
    cycle();
    // matching fields but not a load
    EXE_MemRead = 1'b0; EXE_rt = 5'd12; ID_rs = 5'd12; ID_rt = 5'd1;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL lu_not_load: got %b required %b", outs, O_DEF);
    end
    cycle();
    // load, nonzero rt, no match
    EXE_MemRead = 1'b1; EXE_rt = 5'd12; ID_rs = 5'd13; ID_rt = 5'd14;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL lu_no_match: got %b required %b", outs, O_DEF);
    end
    cycle();
    clear_inputs();
    checks++;
    if (Stall_Cnt !== 6'd2) begin
      failures++;
      $display("FAIL lu_stall_cnt2: got %0d required 2", Stall_Cnt);
    end
    $display("test_load_use done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_div_done();
    int bad;
    do_reset();
    EXE_DivStart = 1'b1;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL div_issue_outs: got %b required %b", outs, O_DEF);
    end
    cycle();
    EXE_DivStart = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (outs !== O_DW) begin
        failures++;
        bad++;
        $display("FAIL div_wait_outs[%0d]: got %b required %b", i, outs, O_DW);
      end
      cycle();
    end
    Div_Done = 1'b1;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL div_done_outs: got %b required %b", outs, O_DEF);
    end
    cycle();
    Div_Done = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL div_back_to_run: got %b required %b", outs, O_DEF);
    end
    checks++;
    if (Stall_Cnt !== 6'd10) begin
      failures++;
      $display("FAIL div_stall_cnt: got %0d required 10", Stall_Cnt);
    end
    $display("test_div_done done checks=%0d failures=%0d wait_errs=%0d", checks, failures, bad);
  endtask

  task automatic test_busy_pend();
    do_reset();
    EXE_DivStart = 1'b1;
    cycle();
    EXE_DivStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_DW) begin
        failures++;
        $display("FAIL pend_wait_outs[%0d]: got %b required %b", i, outs, O_DW);
      end
      cycle();
    end
    // Freeze spans the done pulse.
    for (int i = 0; i < 3; i++) begin
      DCache_Busy = 1'b1;
      Div_Done    = (i == 1);
      #1;
      checks++;
      if (outs !== O_FRZ) begin
        failures++;
        $display("FAIL pend_freeze_outs[%0d]: got %b required %b", i, outs, O_FRZ);
      end
      cycle();
    end
    DCache_Busy = 1'b0;
    Div_Done    = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL pend_exit_outs: got %b required %b", outs, O_DEF);
    end
    cycle();
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL pend_run_outs: got %b required %b", outs, O_DEF);
    end
    checks++;
    if (Stall_Cnt !== 6'd6) begin
      failures++;
      $display("FAIL pend_stall_cnt: got %0d required 6", Stall_Cnt);
    end
    $display("test_busy_pend done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    EXE_DivStart = 1'b1;
    cycle();
    EXE_DivStart = 1'b0;
    bad = 0;
    for (int i = 0; i < DIV_LAT_MAX - 1; i++) begin
      #1;
      checks++;
      if (outs !== O_DW) begin
        failures++;
        bad++;
        $display("FAIL to_wait_outs[%0d]: got %b required %b", i, outs, O_DW);
      end
      cycle();
    end
    #1;
    checks++;
    if (outs !== O_TO) begin
      failures++;
      $display("FAIL to_pulse_outs: got %b required %b", outs, O_TO);
    end
    cycle();
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL to_after_outs: got %b required %b", outs, O_DEF);
    end
    checks++;
    if (Stall_Cnt !== 6'd35) begin
      failures++;
      $display("FAIL to_stall_cnt: got %0d required 35", Stall_Cnt);
    end
    $display("test_timeout done checks=%0d failures=%0d wait_errs=%0d", checks, failures, bad);
  endtask

  task automatic test_exception();
    do_reset();
    EXE_DivStart = 1'b1;
    cycle();
    EXE_DivStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
    end
    Exc_Valid = 1'b1;
    #1;
    checks++;
    if (outs_exc !== O_EXC) begin
      failures++;
      $display("FAIL exc_mid_wait: got %b required %b", outs_exc, O_EXC);
    end
    cycle();
    Exc_Valid = 1'b0;
    #1;
    checks++;
    if (outs !== O_DEF) begin
      failures++;
      $display("FAIL exc_back_to_run: got %b required %b", outs, O_DEF);
    end
    // Exception outranks a cache miss.
    Exc_Valid   = 1'b1;
    ICache_Busy = 1'b1;
    #1;
    checks++;
    if (outs_exc !== O_EXC) begin
      failures++;
      $display("FAIL exc_over_busy: got %b required %b", outs_exc, O_EXC);
    end
    cycle();
    clear_inputs();
    checks++;
    if (Stall_Cnt !== 6'd5) begin
      failures++;
      $display("FAIL exc_stall_cnt: got %0d required 5", Stall_Cnt);
    end
    $display("test_exception done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_branch();
    do_reset();
    EXE_BranchTaken = 1'b1;
    EXE_MemRead = 1'b1; EXE_rt = 5'd4; ID_rs = 5'd4; ID_rt = 5'd2;
    #1;
    checks++;
    if (outs !== O_BR) begin
      failures++;
      $display("FAIL br_over_lu: got %b required %b", outs, O_BR);
    end
    cycle();
    clear_inputs();
    checks++;
    if (Stall_Cnt !== 6'd0) begin
      failures++;
      $display("FAIL br_stall_cnt: got %0d required 0", Stall_Cnt);
    end
    // A cache miss outranks the branch.
    EXE_BranchTaken = 1'b1;
    ICache_Busy     = 1'b1;
    #1;
    checks++;
    if (outs !== O_FRZ) begin
      failures++;
      $display("FAIL busy_over_br: got %b required %b", outs, O_FRZ);
    end
    cycle();
    clear_inputs();
    checks++;
    if (Stall_Cnt !== 6'd1) begin
      failures++;
      $display("FAIL busy_stall_cnt: got %0d required 1", Stall_Cnt);
    end
    $display("test_branch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_saturate();
    do_reset();
    DCache_Busy = 1'b1;
    for (int i = 0; i < 62; i++) begin
      cycle();
    end
    checks++;
    if (Stall_Cnt !== 6'd62) begin
      failures++;
      $display("FAIL sat_pre: got %0d required 62", Stall_Cnt);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
    end
    checks++;
    if (Stall_Cnt !== 6'd63) begin
      failures++;
      $display("FAIL sat_hold: got %0d required 63", Stall_Cnt);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_inputs();
    checks++;
    if (Stall_Cnt !== 6'd0) begin
      failures++;
      $display("FAIL sat_reset_clear: got %0d required 0", Stall_Cnt);
    end
    $display("test_saturate done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div_done();
    test_busy_pend();
    test_timeout();
    test_exception();
    test_branch();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
